// File: rtl/simple_p1_adder_129_pkg.sv
// ----------------------------------------------------------------------------
// simple_p1_adder_129_pkg
// Shared constants and types for the split-carry pipelined adder.
//   ADDER_W    : default operand width in bits
//   ADDER_LO_W : default width of the low slice added in the first stage
//   operand_t  : W-bit unsigned operand
//   sum_t      : (W+1)-bit unsigned sum, MSB is the carry-out
// No ports (package).
// ----------------------------------------------------------------------------
package simple_p1_adder_129_pkg;

  localparam int ADDER_W    = 129;
  localparam int ADDER_LO_W = 64;

  typedef logic [ADDER_W-1:0] operand_t;
  typedef logic [ADDER_W:0]   sum_t;

endpackage : simple_p1_adder_129_pkg

// File: rtl/simple_p1_adder_129_slice.sv
// ----------------------------------------------------------------------------
// p1_slice_adder
// Parameterised N-bit unsigned adder with carry-in and carry-out. Used once
// for the low slice and once for the high slice of simple_p1_adder_129.
// Ports:
//   a, b : N-bit addends
//   cin  : carry-in
//   sum  : N-bit sum (a + b + cin) modulo 2^N
//   cout : carry-out of the N-bit addition
// ----------------------------------------------------------------------------
module p1_slice_adder #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] wide_sum;

  // Zero-extend all three terms so the carry-out lands in bit N.
  assign wide_sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

  assign sum  = wide_sum[N-1:0];
  assign cout = wide_sum[N];

endmodule : p1_slice_adder

// File: rtl/simple_p1_adder_129.sv
// ----------------------------------------------------------------------------
// simple_p1_adder_129
// Wide unsigned adder split at LO_W so that no carry chain spans all W bits.
// Stage 1 adds the low slice and registers the low sum, its carry and the
// untouched high operand slices; stage 2 combinationally adds the high slices
// plus the registered carry. Latency 1 clock, one addition per clock.
//
// Build option SIMPLE_P1_ADDER_COMB_EN: when defined, the stage-1 registers
// are bypassed, full_sum = ain + bin combinationally and clk/rst_n are unused.
//
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (clears stage-1 registers)
//   ain, bin : W-bit unsigned addends
//   full_sum : (W+1)-bit sum, bit W is the carry-out
// ----------------------------------------------------------------------------
module simple_p1_adder_129
  import simple_p1_adder_129_pkg::*;
#(
  parameter int W    = ADDER_W,
  parameter int LO_W = ADDER_LO_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] ain,
  input  logic [W-1:0] bin,
  output logic [W:0]   full_sum
);

  localparam int HI_W = W - LO_W;

  // Stage 1 low-slice adder (carry chain of LO_W bits).
  logic [LO_W-1:0] lo_sum_next;
  logic            lo_carry_next;

  p1_slice_adder #(
    .N (LO_W)
  ) u_lo_adder (
    .a    (ain[LO_W-1:0]),
    .b    (bin[LO_W-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum_next),
    .cout (lo_carry_next)
  );

  // Boundary between the stages: registered in the default build,
  // straight wires in the combinational build.
  logic [LO_W-1:0] lo_sum_reg;
  logic            carry_reg;
  logic [HI_W-1:0] a_hi_reg;
  logic [HI_W-1:0] b_hi_reg;

`ifdef SIMPLE_P1_ADDER_COMB_EN
  assign lo_sum_reg = lo_sum_next;
  assign carry_reg  = lo_carry_next;
  assign a_hi_reg   = ain[W-1:LO_W];
  assign b_hi_reg   = bin[W-1:LO_W];

  // Clock and reset have no function in this build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_sum_reg <= '0;
      carry_reg  <= 1'b0;
      a_hi_reg   <= '0;
      b_hi_reg   <= '0;
    end else begin
      lo_sum_reg <= lo_sum_next;
      carry_reg  <= lo_carry_next;
      a_hi_reg   <= ain[W-1:LO_W];
      b_hi_reg   <= bin[W-1:LO_W];
    end
  end
`endif

  // Stage 2 high-slice adder: the low-slice carry enters as carry-in, so the
  // chain is HI_W+1 bits long and the result lands in the same output cycle.
  logic [HI_W-1:0] hi_sum;
  logic            hi_carry;

  p1_slice_adder #(
    .N (HI_W)
  ) u_hi_adder (
    .a    (a_hi_reg),
    .b    (b_hi_reg),
    .cin  (carry_reg),
    .sum  (hi_sum),
    .cout (hi_carry)
  );

  // With all stage-1 registers cleared, this evaluates to zero during reset.
  assign full_sum = {hi_carry, hi_sum, lo_sum_reg};

endmodule : simple_p1_adder_129

// File: tb/tb_simple_p1_adder_129.sv
// ----------------------------------------------------------------------------
// tb_simple_p1_adder_129
// Self-checking bench for simple_p1_adder_129 (default, pipelined build).
// Expected sums are pushed to a queue when operands are driven on a falling
// edge and popped/compared on the following falling edge, one clock later.
// ----------------------------------------------------------------------------
module tb_simple_p1_adder_129;
  import simple_p1_adder_129_pkg::*;

  localparam int W = ADDER_W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] ain = '0;
  logic [W-1:0] bin = '0;
  logic [W:0]   full_sum;

  sum_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  simple_p1_adder_129 #(
    .W    (ADDER_W),
    .LO_W (ADDER_LO_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ain      (ain),
    .bin      (bin),
    .full_sum (full_sum)
  );

  function automatic operand_t rand_op();
    operand_t r;
    r[31:0]   = $urandom;
    r[63:32]  = $urandom;
    r[95:64]  = $urandom;
    r[127:96] = $urandom;
    r[128]    = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Reset holds the output at zero; first edge after release sums all-ones.
  task automatic test_reset();
    sum_t e;
    rst_n = 1'b0;
    ain   = '1;
    bin   = '1;
    #1;
    vectors++;
    if (full_sum !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected 0", full_sum);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (full_sum !== '0) begin
      miscompares++;
      $display("FAIL reset_hold_clocked: got %h expected 0", full_sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    e = '1;
    e[0] = 1'b0;               // 2^130 - 2
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if (full_sum !== e) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", full_sum, e);
    end else
      $display("txn reset_release sum=%h", full_sum);
  endtask

  // 1+1 appears after the capturing edge and not before it.
  task automatic test_latency();
    sum_t e;
    @(negedge clk);
    ain = '0;
    bin = '0;
    @(negedge clk);
    ain = W'(1);
    bin = W'(1);
    e = 2;
    exp_q.push_back(e);
    #1;
    vectors++;
    if (full_sum !== '0) begin
      miscompares++;
      $display("FAIL latency_early: got %h expected 0", full_sum);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if (full_sum !== e) begin
      miscompares++;
      $display("FAIL latency_one: got %h expected %h", full_sum, e);
    end else
      $display("txn latency sum=%h", full_sum);
  endtask

  // Carry ripples from the low slice into bit LO_W.
  task automatic test_carry_split();
    sum_t e;
    @(negedge clk);
    ain = '0;
    ain[63:0] = '1;
    bin = W'(1);
    e = '0;
    e[64] = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if (full_sum !== e) begin
      miscompares++;
      $display("FAIL carry_split: got %h expected %h", full_sum, e);
    end else
      $display("txn carry_split sum=%h", full_sum);
  endtask

  // 2^128-4 + 5 = 2^128 + 1.
  task automatic test_subtract();
    sum_t e;
    @(negedge clk);
    ain = '0;
    ain[127:2] = '1;
    bin = W'(5);
    e = '0;
    e[128] = 1'b1;
    e[0]   = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if (full_sum !== e) begin
      miscompares++;
      $display("FAIL subtract: got %h expected %h", full_sum, e);
    end else
      $display("txn subtract sum=%h", full_sum);
  endtask

  // Operands held for several cycles give a constant result.
  task automatic test_hold();
    sum_t     e;
    operand_t a, b;
    a = rand_op();
    b = rand_op();
    @(negedge clk);
    ain = a;
    bin = b;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, a} + {1'b0, b});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (full_sum !== e) begin
        miscompares++;
        $display("FAIL hold[%0d]: got %h expected %h", i, full_sum, e);
      end else
        $display("txn hold[%0d] sum=%h", i, full_sum);
    end
  endtask

  // A new random pair every clock for 1000 clocks.
  task automatic test_back_to_back();
    sum_t     e;
    operand_t a, b;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (full_sum !== e) begin
          miscompares++;
          $display("FAIL stream[%0d]: got %h expected %h", i - 1, full_sum, e);
        end else
          $display("txn stream[%0d] sum=%h", i - 1, full_sum);
      end
      a = rand_op();
      b = rand_op();
      ain = a;
      bin = b;
      exp_q.push_back({1'b0, a} + {1'b0, b});
    end
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if (full_sum !== e) begin
      miscompares++;
      $display("FAIL stream[999]: got %h expected %h", full_sum, e);
    end else
      $display("txn stream[999] sum=%h", full_sum);
  endtask

  // Reset pulse between clock edges clears the output at once.
  task automatic test_reset_pulse();
    sum_t     e;
    operand_t a, b;
    a = rand_op();
    b = rand_op();
    a[0] = 1'b1;
    b[0] = 1'b0;               // guarantees a non-zero sum
    @(negedge clk);
    ain = a;
    bin = b;
    exp_q.push_back({1'b0, a} + {1'b0, b});
    @(posedge clk);
    #2;
    e = exp_q.pop_front();
    vectors++;
    if (full_sum !== e) begin
      miscompares++;
      $display("FAIL pulse_pre: got %h expected %h", full_sum, e);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (full_sum !== '0) begin
      miscompares++;
      $display("FAIL pulse_async_clear: got %h expected 0", full_sum);
    end else
      $display("txn pulse_async_clear sum=%h", full_sum);
    exp_q.delete();
    @(negedge clk);
    a = rand_op();
    b = rand_op();
    ain = a;
    bin = b;
    rst_n = 1'b1;
    exp_q.push_back({1'b0, a} + {1'b0, b});
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if (full_sum !== e) begin
      miscompares++;
      $display("FAIL pulse_post: got %h expected %h", full_sum, e);
    end else
      $display("txn pulse_post sum=%h", full_sum);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_carry_split();
    test_subtract();
    test_hold();
    test_back_to_back();
    test_reset_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_simple_p1_adder_129

// File: doc/simple_p1_adder_129.md
SIMPLE_P1_ADDER_129 -- requirements
Module: simple_p1_adder_129

Interface
REQ-001 The module SHALL have parameter W, default 129, meaning the operand width in bits.
REQ-002 The module SHALL have parameter LO_W, default 64, meaning the width of the low slice added in pipeline stage 1 (1 <= LO_W < W).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port ain, input, W bits: unsigned addend A.
REQ-006 The module SHALL have port bin, input, W bits: unsigned addend B.
REQ-007 The module SHALL have port full_sum, output, W+1 bits: the registered sum A+B, with bit W as the carry-out.

Function
REQ-008 full_sum SHALL equal ain+bin sampled at the previous rising edge, computed at full W+1 width with no truncation: latency exactly 1 clock, throughput one addition per clock.
REQ-009 Stage 1 SHALL add ain[LO_W-1:0]+bin[LO_W-1:0] and register the LO_W-bit low sum plus its carry-out, and SHALL register ain[W-1:LO_W] and bin[W-1:LO_W] unchanged.
REQ-010 Stage 2 SHALL be combinational from the stage-1 registers: high part = reg_a_hi + reg_b_hi + reg_carry (W-LO_W+1 bits); full_sum = {high part, reg_lo_sum}.
REQ-011 The longest carry chain SHALL be max(LO_W, W-LO_W+1) bits, never W bits.
REQ-012 No handshake SHALL exist: every clock accepts new operands; operands held constant for several cycles SHALL yield a constant full_sum from the first cycle after they are applied.
REQ-013 The carry from the low slice SHALL propagate into the high slice within the same output cycle: the all-ones low slice plus 1 produces a correct ripple into bit LO_W.
REQ-014 Wrap-around: no overflow SHALL be possible; the maximum result (2^W-1)*2 is representable in W+1 bits.
REQ-015 The block SHALL contain no FSM; its state consists only of the stage-1 registers.

Reset
REQ-016 While rst_n=0, all stage-1 registers SHALL clear immediately (asynchronously), and full_sum SHALL be 0.
REQ-017 Reset asserted mid-stream SHALL discard the in-flight sum; after the first rising edge with rst_n=1, full_sum SHALL reflect the operands sampled at that edge.

Configuration
REQ-018 Macro SIMPLE_P1_ADDER_COMB_EN: when defined, the pipeline registers SHALL be removed, full_sum SHALL equal ain+bin combinationally (latency 0), and clk/rst_n SHALL be unused; when undefined, the 1-stage pipelined behaviour of REQ-008..REQ-017 SHALL apply.

Structure
REQ-019 A shared package SHALL hold the default constants ADDER_W=129 and ADDER_LO_W=64, plus a typedef for the W-bit operand and the (W+1)-bit sum.
REQ-020 One sub-module, p1_slice_adder (a parameterised N-bit adder with carry-in and carry-out), SHALL be instantiated once per stage.

Verification
REQ-021 rst_n=0 with ain=bin=all-ones -> full_sum=0 while in reset; rst_n released, then one clock -> full_sum=2^130-2.
REQ-022 ain=1, bin=1 at edge k -> full_sum=2 after edge k, and not before it.
REQ-023 Carry across the split: ain=2^64-1, bin=1 -> full_sum=2^64 (bit 64 set, all others 0).
REQ-024 Subtract usage: ain={0,~3 over 128 bits}=2^128-4, bin=5 -> full_sum=2^128+1 (bit 128 set, low word 1).
REQ-025 Streaming: distinct random pairs applied on 1000 consecutive clocks -> each full_sum matches its reference sum exactly one cycle later, in order.
REQ-026 Reset pulse mid-stream -> full_sum drops to 0 asynchronously; the first post-reset sum is correct after one clock.
